// File: rtl/hex_display_pager.sv
// Pages a captured wide word onto NUM_DIGITS 7-segment nibble decoders.
// Pages advance on a dwell timer (auto mode) or on a rising edge of the button.
module hex_display_pager #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DWELL      = 50_000_000,
    localparam int unsigned PAGE_W    = 4 * NUM_DIGITS,
    localparam int unsigned PAGES     = DATA_W / PAGE_W,
    localparam int unsigned PW        = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  next_btn,
    input  logic                  auto_en,
    input  logic                  clear,
    output logic [PAGE_W-1:0]     digit_nib,
    output logic [NUM_DIGITS-1:0] digit_blank,
    output logic [PW-1:0]         page_idx,
    output logic                  showing
);

    localparam int unsigned CW = $clog2(DWELL);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t                r_state, w_nxt_state;
    logic [DATA_W-1:0]     r_word, w_nxt_word;
    logic [PW-1:0]         r_page, w_nxt_page;
    logic [CW-1:0]         r_cnt, w_nxt_cnt;
    logic                  r_btn_q;
    logic                  r_ready;
    logic [PAGE_W-1:0]     r_nib, w_nxt_nib;
    logic [NUM_DIGITS-1:0] r_blank;

    logic w_xfer;
    logic w_edge;
    logic w_hit;

    assign w_xfer = data_valid && r_ready;
    assign w_edge = next_btn && !r_btn_q;
    assign w_hit  = auto_en && (r_cnt == CW'(DWELL - 1));

    // State and datapath registers; display outputs are registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_page  <= '0;
            r_cnt   <= '0;
            r_btn_q <= 1'b0;
            r_ready <= 1'b1;
            r_nib   <= '0;
            r_blank <= '1;
        end else begin
            r_state <= w_nxt_state;
            r_word  <= w_nxt_word;
            r_page  <= w_nxt_page;
            r_cnt   <= w_nxt_cnt;
            r_btn_q <= next_btn;
            r_ready <= 1'b1;
            r_nib   <= w_nxt_nib;
            r_blank <= (w_nxt_state == ST_SHOW) ? '0 : '1;
        end
    end

    // Next-state logic: clear beats transfer, transfer beats advance.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_word  = r_word;
        w_nxt_page  = r_page;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!clear && w_xfer) begin
                    w_nxt_state = ST_SHOW;
                    w_nxt_word  = data_in;
                    w_nxt_page  = '0;
                    w_nxt_cnt   = '0;
                end
            end
            ST_SHOW: begin
                if (clear) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_page  = '0;
                    w_nxt_cnt   = '0;
                end else if (w_xfer) begin
                    w_nxt_word  = data_in;
                    w_nxt_page  = '0;
                    w_nxt_cnt   = '0;
                end else if (w_edge || w_hit) begin
                    w_nxt_page  = (r_page == PW'(PAGES - 1)) ? '0 : r_page + PW'(1);
                    w_nxt_cnt   = '0;
                end else if (auto_en) begin
                    w_nxt_cnt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Select the page slice that will be visible next cycle; page 0 holds the MS nibbles.
    always_comb begin
        w_nxt_nib = '0;
        if (w_nxt_state == ST_SHOW) begin
            for (int unsigned p = 0; p < PAGES; p++) begin
                if (w_nxt_page == PW'(p)) begin
                    w_nxt_nib = w_nxt_word[DATA_W-1-p*PAGE_W -: PAGE_W];
                end
            end
        end
    end

    assign data_ready  = r_ready;
    assign digit_nib   = r_nib;
    assign digit_blank = r_blank;
    assign page_idx    = r_page;
    assign showing     = (r_state == ST_SHOW);

endmodule

// File: tb/tb_hex_display_pager.sv
// Bench for hex_display_pager: directed vector table, hand sequences, randomized model check.
module tb_hex_display_pager;

    localparam int unsigned DWELL = 4;
    localparam int unsigned PAGES = 4;
    localparam logic [127:0] DW = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic         next_btn = 1'b0;
    logic         auto_en = 1'b0;
    logic         clear = 1'b0;
    logic [31:0]  digit_nib;
    logic [7:0]   digit_blank;
    logic [1:0]   page_idx;
    logic         showing;

    int n_checks = 0;
    int n_fail   = 0;

    hex_display_pager #(.DATA_W(128), .NUM_DIGITS(8), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .next_btn(next_btn), .auto_en(auto_en), .clear(clear),
        .digit_nib(digit_nib), .digit_blank(digit_blank), .page_idx(page_idx), .showing(showing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, c, b, a;
        int          reps;
        logic        each;
        logic [31:0] nib;
        logic [1:0]  page;
        logic        show;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic c, logic b, logic a, int reps, logic each,
                                logic [31:0] nib, logic [1:0] page, logic show);
        vec_t t;
        t.v = v; t.c = c; t.b = b; t.a = a; t.reps = reps; t.each = each;
        t.nib = nib; t.page = page; t.show = show;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic [31:0] nib, logic [1:0] page, logic show);
        check({tag, " nib"},   digit_nib, nib);
        check({tag, " blank"}, 32'(digit_blank), show ? 32'h0 : 32'hFF);
        check({tag, " page"},  32'(page_idx), 32'(page));
        check({tag, " show"},  32'(showing), 32'(show));
        check({tag, " ready"}, 32'(data_ready), 32'h1);
    endtask

    task automatic drive(logic v, logic c, logic b, logic a);
        data_valid = v; clear = c; next_btn = b; auto_en = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, advanced once per clock from the inputs seen at the edge.
    logic         m_show;
    logic [127:0] m_word;
    int           m_page, m_cnt;
    logic         m_prev;

    task automatic model_edge();
        bit adv;
        if (clear) begin
            m_show = 0; m_page = 0; m_cnt = 0;
        end else if (data_valid) begin
            m_show = 1; m_word = data_in; m_page = 0; m_cnt = 0;
        end else if (m_show) begin
            adv = (next_btn && !m_prev) || (auto_en && m_cnt == DWELL - 1);
            if (adv) begin
                m_page = (m_page + 1) % PAGES;
                m_cnt  = 0;
            end else if (auto_en) begin
                m_cnt = m_cnt + 1;
            end
        end
        m_prev = next_btn;
    endtask

    function automatic logic [31:0] model_nib();
        logic [127:0] sh;
        if (!m_show) return 32'h0;
        sh = m_word >> (32 * (PAGES - 1 - m_page));
        return sh[31:0];
    endfunction

    initial begin
        // Reset state and idle period.
        #12;
        check_all("in_reset", 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("idle", 32'h0, 2'd0, 1'b0);
        end

        data_in = DW;
        // Load/hold, auto dwell with wrap, button presses, coincident advance, reload, clear.
        vecs.push_back(mk(1,0,0,0, 1,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,0,0,20,1, 32'h00112233,0,1));
        vecs.push_back(mk(1,0,0,1, 1,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,0,1, 3,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,0,1, 1,0, 32'h44556677,1,1));
        vecs.push_back(mk(0,0,0,1, 4,0, 32'h8899AABB,2,1));
        vecs.push_back(mk(0,0,0,1, 4,0, 32'hCCDDEEFF,3,1));
        vecs.push_back(mk(0,0,0,1, 4,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,1,0, 1,0, 32'h44556677,1,1));
        vecs.push_back(mk(0,0,1,0, 4,1, 32'h44556677,1,1));
        vecs.push_back(mk(0,0,0,0, 1,0, 32'h44556677,1,1));
        vecs.push_back(mk(0,0,1,0, 1,0, 32'h8899AABB,2,1));
        vecs.push_back(mk(0,0,0,0, 1,0, 32'h8899AABB,2,1));
        vecs.push_back(mk(0,0,0,1, 3,0, 32'h8899AABB,2,1));
        vecs.push_back(mk(0,0,1,1, 1,0, 32'hCCDDEEFF,3,1));
        vecs.push_back(mk(0,0,0,1, 1,0, 32'hCCDDEEFF,3,1));
        vecs.push_back(mk(1,0,0,1, 1,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,0,1, 3,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,0,1, 1,0, 32'h44556677,1,1));
        vecs.push_back(mk(1,1,0,1, 1,0, 32'h0,0,0));
        vecs.push_back(mk(0,0,1,1, 3,1, 32'h0,0,0));
        vecs.push_back(mk(1,0,1,1, 1,0, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,1,0, 3,1, 32'h00112233,0,1));
        vecs.push_back(mk(0,0,0,0, 1,0, 32'h00112233,0,1));

        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].c, vecs[k].b, vecs[k].a);
            for (int r = 0; r < vecs[k].reps; r++) begin
                step();
                if (vecs[k].each || r == vecs[k].reps - 1)
                    check_all($sformatf("vec%0d", k), vecs[k].nib, vecs[k].page, vecs[k].show);
            end
        end

        // Asynchronous reset in the middle of a display.
        drive(1,0,0,0); step(); check_all("mr_load", 32'h00112233, 2'd0, 1'b1);
        drive(0,0,1,0); step(); check_all("mr_btn", 32'h44556677, 2'd1, 1'b1);
        drive(0,0,0,0);
        #2 rst_n = 1'b0;
        #1 check_all("mr_async", 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); check_all("mr_after", 32'h0, 2'd0, 1'b0);

        // Randomized traffic against the reference model.
        m_show = 0; m_word = '0; m_page = 0; m_cnt = 0; m_prev = 0;
        for (int i = 0; i < 600; i++) begin
            data_valid = ($urandom_range(0, 9) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            auto_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) next_btn = ~next_btn;
            data_in    = {$urandom, $urandom, $urandom, $urandom};
            model_edge();
            step();
            check_all($sformatf("rnd%0d", i), model_nib(), 2'(m_page), m_show);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
